// File: rtl/csr_access_unit.sv
// CSR access unit: turns decoded CSRRW/RS/RC (and immediate forms) into READ/WRITE
// command sequences toward the CSR file and returns the old CSR value for rd writeback.
module csr_access_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_csr,
    input  logic [XLEN-1:0]   req_src,
    input  logic              req_rs1_zero,
    input  logic [4:0]        req_rd,
    input  logic              kill,
    output logic [1:0]        csr_cmd,
    output logic [ADDR_W-1:0] csr_addr,
    output logic [XLEN-1:0]   csr_wdata,
    input  logic [XLEN-1:0]   csr_rdata,
    input  logic              csr_stall,
    input  logic              read_illegal,
    input  logic              write_illegal,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [4:0]        resp_rd,
    output logic              resp_illegal
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;
    typedef enum logic [1:0] {OP_RW, OP_RS, OP_RC} op_t;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    state_t            state, state_next;
    op_t               req_kind, op_q;
    logic [ADDR_W-1:0] csr_q;
    logic [XLEN-1:0]   src_q, old_q, resp_data_q, write_value;
    logic [4:0]        rd_q;
    logic              do_read_q, do_write_q, resp_illegal_q;
    logic              accept, req_do_read, req_do_write, read_fault;

    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
        req_kind = OP_RW;
        case (req_op)
            3'd2, 3'd6: req_kind = OP_RS;
            3'd3, 3'd7: req_kind = OP_RC;
            default:    req_kind = OP_RW;
        endcase
    end

    assign req_do_write = (req_kind == OP_RW) || !req_rs1_zero;
    assign req_do_read  = !((req_kind == OP_RW) && (req_rd == 5'd0));
    assign accept       = (state == S_IDLE) && req_valid && !kill;
    // A read that precedes a write also fails if the later write would be illegal.
    assign read_fault   = read_illegal || (do_write_q && write_illegal);

    always_comb begin
        write_value = src_q;
        case (op_q)
            OP_RS:   write_value = old_q | src_q;
            OP_RC:   write_value = old_q & ~src_q;
            default: write_value = src_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = req_do_read ? S_READ : S_WRITE;
            S_READ: begin
                if (kill)            state_next = S_IDLE;
                else if (!csr_stall) state_next = (read_fault || !do_write_q) ? S_RESP : S_WRITE;
            end
            S_WRITE: if (!csr_stall) state_next = S_RESP;
            S_RESP:  if (kill || resp_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        csr_cmd      = CMD_NONE;
        csr_addr     = '0;
        csr_wdata    = '0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        resp_rd      = '0;
        resp_illegal = 1'b0;
        case (state)
            S_IDLE: req_ready = !kill;
            S_READ: begin
                csr_cmd  = CMD_READ;
                csr_addr = csr_q;
            end
            S_WRITE: begin
                // The command is suppressed while the address decodes as write-illegal.
                csr_cmd   = write_illegal ? CMD_NONE : CMD_WRITE;
                csr_addr  = csr_q;
                csr_wdata = write_value;
            end
            S_RESP: begin
                resp_valid   = 1'b1;
                resp_data    = resp_data_q;
                resp_rd      = rd_q;
                resp_illegal = resp_illegal_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q           <= OP_RW;
            csr_q          <= '0;
            src_q          <= '0;
            rd_q           <= '0;
            do_read_q      <= 1'b0;
            do_write_q     <= 1'b0;
            old_q          <= '0;
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    op_q           <= req_kind;
                    csr_q          <= req_csr;
                    src_q          <= req_src;
                    rd_q           <= req_rd;
                    do_read_q      <= req_do_read;
                    do_write_q     <= req_do_write;
                    old_q          <= '0;
                    resp_data_q    <= '0;
                    resp_illegal_q <= 1'b0;
                end
                S_READ: if (!kill && !csr_stall) begin
                    if (read_fault) begin
                        resp_illegal_q <= 1'b1;
                        resp_data_q    <= '0;
                    end else begin
                        old_q <= csr_rdata;
                        if (!do_write_q) resp_data_q <= csr_rdata;
                    end
                end
                S_WRITE: if (!csr_stall) begin
                    if (write_illegal) begin
                        resp_illegal_q <= 1'b1;
                        resp_data_q    <= '0;
                    end else begin
                        resp_data_q <= old_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed test-plan cases plus randomized
// accesses compared against a transaction-level model of the CSR instruction semantics.
module tb_csr_access_unit;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset_n, req_valid, req_ready, req_rs1_zero, kill;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_csr, csr_addr;
    logic [XLEN-1:0]   req_src, csr_wdata, csr_rdata, resp_data;
    logic [4:0]        req_rd, resp_rd;
    logic [1:0]        csr_cmd;
    logic              csr_stall, read_illegal, write_illegal;
    logic              resp_valid, resp_ready, resp_illegal;
    logic              stall_want;
    logic              pre_en;
    logic [ADDR_W-1:0] pre_addr;
    logic [XLEN-1:0]   pre_data;

    logic [XLEN-1:0] csr_file [0:4095];
    logic [XLEN-1:0] ref_mem  [0:4095];
    logic [ADDR_W-1:0] addr_pool [0:6];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_csr(req_csr),
        .req_src(req_src), .req_rs1_zero(req_rs1_zero), .req_rd(req_rd), .kill(kill),
        .csr_cmd(csr_cmd), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .csr_stall(csr_stall), .read_illegal(read_illegal), .write_illegal(write_illegal),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_illegal(resp_illegal)
    );

    function automatic logic rd_ill_f(input logic [ADDR_W-1:0] a);
        return a == 12'h7C0;
    endfunction

    function automatic logic wr_ill_f(input logic [ADDR_W-1:0] a);
        return (a[11:10] == 2'b11) || (a == 12'h7C0);
    endfunction

    // Behavioural CSR file: address decode, stall only against an active command.
    assign csr_rdata     = csr_file[csr_addr];
    assign read_illegal  = rd_ill_f(csr_addr);
    assign write_illegal = wr_ill_f(csr_addr);
    assign csr_stall     = stall_want && (csr_cmd != 2'd0);

    always @(posedge clk) begin
        if (pre_en)                                csr_file[pre_addr] <= pre_data;
        else if (csr_cmd == 2'd2 && !csr_stall)    csr_file[csr_addr] <= csr_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issues one access from IDLE (called at a negedge) and checks it end to end.
    task automatic run_txn(input logic [2:0] op, input logic [ADDR_W-1:0] addr,
                           input logic [XLEN-1:0] src, input logic rs1z, input logic [4:0] rd,
                           input int rstalls, input int wstalls, input int stall_pct,
                           input int resp_wait);
        logic is_rw, is_rs, do_w, do_r, ill, done, prev_stall;
        logic [XLEN-1:0] old, newv, prev_wdata;
        logic [1:0] prev_cmd;
        logic [ADDR_W-1:0] prev_addr;
        int reads, writes, wcyc, stalls, k, rs_left, ws_left, base_lat;

        is_rw = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd5);
        is_rs = (op == 3'd2) || (op == 3'd6);
        do_w  = is_rw || !rs1z;
        do_r  = !(is_rw && rd == 5'd0);
        ill   = (do_r && rd_ill_f(addr)) || (do_w && wr_ill_f(addr));
        old   = do_r ? ref_mem[addr] : '0;
        newv  = is_rw ? src : (is_rs ? (old | src) : (old & ~src));
        base_lat = 1 + (do_r ? 1 : 0) + ((do_w && !(do_r && ill)) ? 1 : 0);

        req_valid = 1'b1; req_op = op; req_csr = addr; req_src = src;
        req_rs1_zero = rs1z; req_rd = rd; stall_want = 1'b0;
        #1 check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_src = $urandom; req_csr = ADDR_W'($urandom);
        k = 1; reads = 0; writes = 0; wcyc = 0; stalls = 0; done = 1'b0;
        rs_left = rstalls; ws_left = wstalls; prev_stall = 1'b0;
        prev_cmd = '0; prev_addr = '0; prev_wdata = '0;
        while (!done && k < 64) begin
            stall_want = 1'b0;
            if (csr_cmd == 2'd1 && rs_left > 0) begin
                stall_want = 1'b1; rs_left--;
            end else if (csr_cmd == 2'd2 && ws_left > 0) begin
                stall_want = 1'b1; ws_left--;
            end else if (int'($urandom_range(99)) < stall_pct) begin
                stall_want = 1'b1;
            end
            #1;
            if (prev_stall) begin
                check("stall_hold_cmd",   {30'd0, csr_cmd}, {30'd0, prev_cmd});
                check("stall_hold_addr",  {20'd0, csr_addr}, {20'd0, prev_addr});
                check("stall_hold_wdata", csr_wdata, prev_wdata);
            end
            if (resp_valid) begin
                done = 1'b1;
            end else begin
                if (csr_cmd != 2'd0) check("cmd_addr", {20'd0, csr_addr}, {20'd0, addr});
                if (csr_cmd == 2'd1 && !csr_stall) reads++;
                if (csr_cmd == 2'd2) begin
                    wcyc++;
                    check("wdata", csr_wdata, newv);
                    if (!csr_stall) writes++;
                end
                if (csr_stall) stalls++;
                prev_stall = csr_stall; prev_cmd = csr_cmd;
                prev_addr = csr_addr; prev_wdata = csr_wdata;
                @(negedge clk);
                k++;
            end
        end
        stall_want = 1'b0;
        check("resp_seen", {31'd0, done}, 32'd1);
        check("latency", k, base_lat + stalls);
        check("read_cycles", reads, do_r ? 1 : 0);
        check("committed_writes", writes, (do_w && !ill) ? 1 : 0);
        if (ill) check("write_cycles_when_illegal", wcyc, 0);
        check("resp_data", resp_data, ill ? '0 : old);
        check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
        check("resp_illegal", {31'd0, resp_illegal}, {31'd0, ill});
        for (int i = 0; i < resp_wait; i++) begin
            @(negedge clk);
            check("resp_hold_valid", {31'd0, resp_valid}, 32'd1);
            check("resp_hold_data", resp_data, ill ? '0 : old);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_drop", {31'd0, resp_valid}, 32'd0);
        check("back_idle", {31'd0, req_ready}, 32'd1);
        if (do_w && !ill) ref_mem[addr] = newv;
        check("csr_file", csr_file[addr], ref_mem[addr]);
    endtask

    initial begin
        logic [2:0] op;
        logic       rz;
        logic [4:0] rd;
        logic [ADDR_W-1:0] a;
        logic [XLEN-1:0] s;

        addr_pool[0] = 12'h340; addr_pool[1] = 12'h341; addr_pool[2] = 12'h300;
        addr_pool[3] = 12'h305; addr_pool[4] = 12'hC00; addr_pool[5] = 12'hC01;
        addr_pool[6] = 12'h7C0;
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_csr = '0; req_src = '0;
        req_rs1_zero = 1'b0; req_rd = '0; kill = 1'b0; resp_ready = 1'b0;
        stall_want = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        @(negedge clk);
        for (int i = 0; i < 7; i++) preload(addr_pool[i], $urandom);

        check("rst_req_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_csr_cmd",    {30'd0, csr_cmd}, 32'd0);
        check("rst_csr_addr",   {20'd0, csr_addr}, 32'd0);
        check("rst_csr_wdata",  csr_wdata, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data",  resp_data, 32'd0);
        check("rst_resp_rd",    {27'd0, resp_rd}, 32'd0);
        check("rst_resp_ill",   {31'd0, resp_illegal}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Test-plan directed cases.
        preload(12'h340, 32'h0000_0011);
        run_txn(3'd1, 12'h340, 32'hDEAD_BEEF, 1'b0, 5'd5, 0, 0, 0, 0);
        preload(12'h341, 32'h0000_0F0F);
        run_txn(3'd2, 12'h341, 32'h0000_00F0, 1'b0, 5'd7, 0, 0, 0, 0);
        preload(12'h341, 32'h0000_0F0F);
        run_txn(3'd3, 12'h341, 32'h0000_00F0, 1'b0, 5'd7, 0, 0, 0, 1);
        run_txn(3'd2, 12'h341, 32'h0, 1'b1, 5'd8, 0, 0, 0, 0);
        run_txn(3'd1, 12'h300, 32'h0000_CAFE, 1'b0, 5'd0, 0, 0, 0, 0);
        run_txn(3'd1, 12'h7C0, 32'h1, 1'b0, 5'd4, 0, 0, 0, 0);
        run_txn(3'd5, 12'hC00, 32'h55, 1'b0, 5'd0, 0, 0, 0, 0);
        run_txn(3'd6, 12'hC00, 32'h0, 1'b1, 5'd10, 0, 0, 0, 0);
        run_txn(3'd1, 12'h340, 32'h1234_5678, 1'b0, 5'd9, 3, 2, 0, 4);

        // Randomized accesses with random stalls and writeback backpressure.
        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(7));
            a  = addr_pool[$urandom_range(6)];
            rz = ($urandom_range(3) == 0);
            s  = rz ? '0 : $urandom;
            rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
            run_txn(op, a, s, rz, rd, 0, 0, 30, $urandom_range(2));
        end

        // kill in READ: back to IDLE, no write.
        preload(12'h341, 32'hA5A5_0001);
        req_valid = 1'b1; req_op = 3'd1; req_csr = 12'h341; req_src = 32'h0BAD_0BAD;
        req_rs1_zero = 1'b0; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b1; stall_want = 1'b1;
        #1 check("kill_rd_in_read", {30'd0, csr_cmd}, 32'd1);
        @(negedge clk);
        kill = 1'b0; stall_want = 1'b0;
        #1 check("kill_rd_cmd", {30'd0, csr_cmd}, 32'd0);
        check("kill_rd_resp", {31'd0, resp_valid}, 32'd0);
        check("kill_rd_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        check("kill_rd_cmd2", {30'd0, csr_cmd}, 32'd0);
        check("kill_rd_nowrite", csr_file[12'h341], 32'hA5A5_0001);

        // kill in WRITE is ignored; kill in RESP discards the response.
        req_valid = 1'b1; req_op = 3'd1; req_csr = 12'h300; req_src = 32'h7777_0000;
        req_rs1_zero = 1'b0; req_rd = 5'd0;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b1;
        #1 check("kill_wr_cmd", {30'd0, csr_cmd}, 32'd2);
        @(negedge clk);
        #1 check("kill_wr_resp", {31'd0, resp_valid}, 32'd1);
        @(negedge clk);
        kill = 1'b0;
        #1 check("kill_resp_drop", {31'd0, resp_valid}, 32'd0);
        check("kill_resp_ready", {31'd0, req_ready}, 32'd1);
        check("kill_wr_commit", csr_file[12'h300], 32'h7777_0000);
        ref_mem[12'h300] = 32'h7777_0000;

        // kill in IDLE blocks acceptance.
        @(negedge clk);
        req_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        #1 check("kill_idle_cmd", {30'd0, csr_cmd}, 32'd0);
        check("kill_idle_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        check("kill_idle_cmd2", {30'd0, csr_cmd}, 32'd0);
        check("kill_idle_resp", {31'd0, resp_valid}, 32'd0);

        // Reset while in WRITE abandons the access.
        preload(12'h305, 32'h1357_9BDF);
        req_valid = 1'b1; req_op = 3'd1; req_csr = 12'h305; req_src = 32'hFFFF_0000;
        req_rs1_zero = 1'b0; req_rd = 5'd2;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 check("rst_wr_in_write", {30'd0, csr_cmd}, 32'd2);
        reset_n = 1'b0; stall_want = 1'b1;
        @(negedge clk);
        reset_n = 1'b1; stall_want = 1'b0;
        #1 check("rst_wr_cmd", {30'd0, csr_cmd}, 32'd0);
        check("rst_wr_ready", {31'd0, req_ready}, 32'd1);
        check("rst_wr_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check("rst_wr_cmd2", {30'd0, csr_cmd}, 32'd0);
        check("rst_wr_nowrite", csr_file[12'h305], 32'h1357_9BDF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR command interface: converts decoded CSR instructions (CSRRW/RS/RC and their immediate forms) into read/write command sequences toward the CSR file.
- Performs the read-modify-write, honours csr_stall, and reports illegal accesses.
- Returns the old CSR value for rd writeback.
- Sits between the execute stage and the CSR file.

Parameters:
- XLEN, 32, data width of CSR values and operands.
- ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  execute stage presents a CSR instruction
- req_ready  out  1  unit can accept a request
- req_op  in  3  funct3: 1=RW, 2=RS, 3=RC, 5=RWI, 6=RSI, 7=RCI; 0/4 treated as RW
- req_csr  in  ADDR_W  CSR address
- req_src  in  XLEN  rs1 value, or zero-extended zimm for immediate forms
- req_rs1_zero  in  1  rs1 index or zimm is zero
- req_rd  in  5  destination register index
- kill  in  1  pipeline flush
- csr_cmd  out  2  0=NONE, 1=READ, 2=WRITE
- csr_addr  out  ADDR_W  address driven to CSR file
- csr_wdata  out  XLEN  write data
- csr_rdata  in  XLEN  read data, valid in the cycle csr_cmd=READ and csr_stall=0
- csr_stall  in  1  CSR file not ready; current command must be held
- read_illegal  in  1  decode result for csr_addr
- write_illegal  in  1  decode result for csr_addr
- resp_valid  out  1  result available
- resp_ready  in  1  writeback accepts result
- resp_data  out  XLEN  old CSR value (0 when no read was performed)
- resp_rd  out  5  destination index
- resp_illegal  out  1  access was illegal; no architectural write occurred

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State IDLE.
  - All outputs 0 except req_ready=1.
  - Internal latches cleared.
  - Reset mid-operation abandons the access; no further commands are issued.
- Derived per request:
  - do_write = RW/RWI, or req_rs1_zero=0.
  - do_read = not (RW/RWI with req_rd=0).
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1, csr_cmd=NONE.
  - On req_valid: latch op/csr/src/rd/do_read/do_write.
  - Next state is READ if do_read, else WRITE.
- READ:
  - csr_cmd=READ, csr_addr=latched csr.
  - If csr_stall=1: hold all outputs and remain.
  - Else if read_illegal, or (do_write and write_illegal): resp_illegal:=1, resp_data:=0, go RESP.
  - Else capture old:=csr_rdata. Go WRITE if do_write, else RESP with resp_data:=old.
- WRITE:
  - csr_cmd=WRITE.
  - csr_wdata: RW = src; RS = old OR src; RC = old AND NOT src. Computed combinationally from the latched values, XLEN-bit bitwise, no carry.
  - If csr_stall=1: hold and remain.
  - Else if write_illegal (only reachable on the no-read path): resp_illegal:=1, go RESP.
  - Else the write is committed this cycle. Go RESP with resp_data=old, or 0 if no read was performed.
- RESP:
  - resp_valid=1, csr_cmd=NONE.
  - Stay until resp_ready=1, then go IDLE.
  - A new request is not accepted in the same cycle; minimum 1 idle cycle between accesses.
- Latency with no stall:
  - Read+write: request accepted at T, READ at T+1, WRITE at T+2, resp_valid at T+3.
  - Read-only or write-only: resp_valid at T+2.
- kill:
  - In READ or RESP: return to IDLE next cycle, no write issued, resp_valid drops.
  - In WRITE: ignored; the write completes, after which kill in RESP discards the response.
  - In IDLE: blocks acceptance that cycle.
- csr_cmd is never WRITE when the access is illegal.
- Exactly one WRITE cycle with csr_stall=0 per committed access.

Test Plan:
- CSRRW csr=0x340, src=0xDEADBEEF, rd=5, CSR holds 0x11 -> READ then WRITE wdata=0xDEADBEEF; resp_data=0x11, resp_rd=5, resp_illegal=0; resp_valid at T+3.
- CSRRS src=0x0000_00F0 on old=0x0000_0F0F -> wdata=0x0000_0FFF. CSRRC same operands -> wdata=0x0000_0F0F. CSRRS with rs1_zero=1 -> no WRITE cycle, resp at T+2.
- CSRRW with rd=0 -> no READ cycle, single WRITE, resp_data=0.
- read_illegal=1 in READ -> no WRITE issued, resp_illegal=1, resp_data=0. Write-only path with write_illegal=1 -> resp_illegal=1, no committed write.
- csr_stall held 3 cycles in READ and 2 in WRITE -> csr_cmd/addr/wdata stable throughout; resp_valid at T+8; resp held 4 cycles with resp_ready=0.
- kill in READ -> IDLE next cycle, no WRITE; reset_n=0 while in WRITE -> csr_cmd=0 and req_ready=1 after the edge.
